// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, taken-branch
// flushes and memory-wait holds, plus a saturating stall counter and timeout flag.
module pipeline_hazard_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_WAIT  = 8,
    parameter int FLUSH_LEN = 1
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [2:0]       IDRs1,
    input  logic [2:0]       IDRs2,
    input  logic             IDUsesRs1,
    input  logic             IDUsesRs2,
    input  logic [2:0]       EXRd,
    input  logic             EXMemRead,
    input  logic             EXRegWrite,
    input  logic             EXBranchTaken,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXBubble,
    output logic             PipeHold,
    output logic [CNT_W-1:0] StallCount,
    output logic             MemTimeout
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

    state_t            state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_nx;
    logic [1:0]        flush_cnt, flush_nx;
    logic              timeout_set;
    logic              lu, ms, stall;

    assign lu = EXMemRead && EXRegWrite && (EXRd != 3'd0) &&
                ((IDUsesRs1 && (IDRs1 == EXRd)) || (IDUsesRs2 && (IDRs2 == EXRd)));
    assign ms = MemReq && !MemReady;

    always_comb begin
        state_nx    = state;
        wait_nx     = wait_cnt;
        flush_nx    = flush_cnt;
        timeout_set = 1'b0;
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IFIDFlush   = 1'b0;
        IDEXBubble  = 1'b0;
        PipeHold    = 1'b0;

        case (state)
            RUN: begin
                if (ms) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    PipeHold  = 1'b1;
                    wait_nx   = WAIT_W'(1);
                    state_nx  = MEMWAIT;
                end else if (EXBranchTaken) begin
                    IFIDFlush  = 1'b1;
                    IDEXBubble = 1'b1;
                    if (FLUSH_LEN > 1) begin
                        flush_nx = 2'(FLUSH_LEN - 1);
                        state_nx = FLUSH;
                    end
                end else if (lu) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXBubble = 1'b1;
                end
            end
            MEMWAIT: begin
                if (MemReady) begin
                    wait_nx  = '0;
                    state_nx = RUN;
                end else begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    PipeHold  = 1'b1;
                    // Checked before the increment so a counter sized exactly for MAX_WAIT never wraps.
                    if (wait_cnt >= WAIT_LAST) begin
                        timeout_set = 1'b1;
                        wait_nx     = '0;
                        state_nx    = RUN;
                    end else begin
                        wait_nx = wait_cnt + 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (ms) begin
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    PipeHold  = 1'b1;
                    wait_nx   = WAIT_W'(1);
                    flush_nx  = '0;
                    state_nx  = MEMWAIT;
                end else begin
                    IFIDFlush  = 1'b1;
                    IDEXBubble = 1'b1;
                    flush_nx   = flush_cnt - 2'd1;
                    if (flush_cnt <= 2'd1) begin
                        state_nx = RUN;
                    end
                end
            end
            default: state_nx = RUN;
        endcase

        if (!Reset) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
            PipeHold   = 1'b0;
        end
    end

    assign stall = !PCWrite || IFIDFlush;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= RUN;
            wait_cnt   <= '0;
            flush_cnt  <= '0;
            StallCount <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            flush_cnt <= flush_nx;
            if (stall && (StallCount != '1)) begin
                StallCount <= StallCount + 1'b1;
            end
            if (timeout_set) begin
                MemTimeout <= 1'b1;
            end
        end
    end

endmodule
